mem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port: accepts load/store requests from the core over a valid/ready

---
 rtl/mem_acc_pkg.sv | 15 +
 rtl/mem_acc_addr_gen.sv | 38 +++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_acc_pkg.sv
// Shared types and default widths for the data-memory access controller.
package mem_acc_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RESP  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_acc_addr_gen.sv
// Burst address generator: holds the current address and beats remaining,
// increments with natural wrap at the top of the address space.
module mem_acc_addr_gen
  import mem_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beats_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_beats_left <= '0;
    end else if (i_load) begin
      r_addr       <= i_addr;
      r_beats_left <= i_len;
    end else if (i_adv) begin
      r_addr       <= r_addr + 1'b1;
      r_beats_left <= r_beats_left - 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_beats_left == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the data memory with burst loads and a registered
// response channel. Define MEM_ACC_WPROT_EN to drop stores at/above WPROT_BASE.
module mem_access_ctrl
  import mem_acc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
`ifdef MEM_ACC_WPROT_EN
  ,
  parameter logic [ADDR_W-1:0] WPROT_BASE = 8'hF0
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              err,
  output logic              busy,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_valid, r_rsp_last, r_wr_done, r_err;
  logic              w_accept, w_hs, w_last, w_prot;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept = req_valid & (r_state == IDLE);
  assign w_hs     = (r_state == RESP) & rsp_ready;

  mem_acc_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_addr (req_addr),
    .i_len  (req_len),
    .i_adv  (w_hs & ~w_last),
    .o_addr (w_addr),
    .o_last (w_last)
  );

`ifdef MEM_ACC_WPROT_EN
  assign w_prot = (w_addr >= WPROT_BASE);
`else
  assign w_prot = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = req_we ? WRITE : READ;
      READ:    w_next = RESP;
      RESP:    if (w_hs) w_next = w_last ? IDLE : READ;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Response registers capture the comb memory read at the end of READ and
  // stay frozen through RESP until the core takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else if (r_state == READ) begin
      r_rsp_data  <= mem_read_data;
      r_rsp_valid <= 1'b1;
      r_rsp_last  <= w_last;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdata   <= '0;
      r_wr_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept && req_we) r_wdata <= req_wdata;
      r_wr_done <= (r_state == WRITE);
      r_err     <= (r_state == WRITE) & w_prot;
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_last       = r_rsp_last;
  assign wr_done        = r_wr_done;
  assign err            = r_err;
  assign mem_rd_en      = (r_state == READ);
  assign mem_wr_en      = (r_state == WRITE) & ~rst & ~w_prot;
  assign mem_addr       = w_addr;
  assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl against a comb-read/posedge-write memory.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          wr_done, err, busy;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done), .err(err), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  assign mem_read_data = mem_rd_en ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_write_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] rd_addr_q[$];
  beat_t         b;
  int unsigned   n_checks, n_fail;
  int unsigned   rd_cnt, wr_cnt, wr_done_cnt, err_cnt, pop_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        rd_cnt++;
        rd_addr_q.push_back(mem_addr);
      end
      if (mem_wr_en) wr_cnt++;
      if (wr_done)   wr_done_cnt++;
      if (err)       err_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          b = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(b.data));
          check("rsp_last", 32'(rsp_last), 32'(b.last));
          pop_cnt++;
        end
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    beat_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Returns at accept-edge + #1 with req_valid dropped.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [DW-1:0] d);
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l; req_wdata = d;
    k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || exp_q.size() != 0) && k < 300);
    if (k >= 300) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt, r0, r1, w0, d0, e0, p0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 16'd2; mem[1] = 16'd3; mem[2] = 16'd10; mem[3] = 16'd15;
    mem[8'hFF] = 16'h00AA; mem[8'hF0] = 16'h5555;
    n_checks = 0; n_fail = 0;
    rd_cnt = 0; wr_cnt = 0; wr_done_cnt = 0; err_cnt = 0; pop_cnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_en", 32'({mem_rd_en, mem_wr_en, wr_done, err}), 32'd0);

    // 4-beat burst, 2 cycles per beat
    push_exp(16'd2, 1'b0); push_exp(16'd3, 1'b0); push_exp(16'd10, 1'b0); push_exp(16'd15, 1'b1);
    issue(1'b0, 8'h00, 4'd3, '0);
    cnt = 0;
    while (busy && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t1_burst_cycles", cnt, 32'd8);
    check("t1_drained", exp_q.size(), 32'd0);

    // Address wrap FF -> 00
    rd_addr_q.delete();
    push_exp(16'h00AA, 1'b0); push_exp(16'd2, 1'b1);
    issue(1'b0, 8'hFF, 4'd1, '0);
    wait_done();
    check("t2_rd_count", rd_addr_q.size(), 32'd2);
    if (rd_addr_q.size() >= 2) begin
      check("t2_addr0", 32'(rd_addr_q[0]), 32'hFF);
      check("t2_addr1", 32'(rd_addr_q[1]), 32'h00);
    end

    // Backpressure: response held, no next read until handshake
    rsp_ready = 1'b0;
    push_exp(16'd10, 1'b0); push_exp(16'd15, 1'b1);
    r0 = rd_cnt;
    issue(1'b0, 8'h02, 4'd1, '0);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) check("t3_valid_timeout", 32'd0, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", 32'(rsp_data), 32'd10);
      check("t3_hold_valid", 32'(rsp_valid), 32'd1);
    end
    check("t3_hold_rd", rd_cnt - r0, 32'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();
    check("t3_total_rd", rd_cnt - r0, 32'd2);

    // Store (req_len ignored) then readback
    w0 = wr_cnt; d0 = wr_done_cnt; e0 = err_cnt;
    issue(1'b1, 8'h05, 4'd7, 16'h1234);
    @(negedge clk);
    check("t4_wr_en", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    check("t4_wr_done", 32'(wr_done), 32'd1);
    check("t4_wr_en_off", 32'(mem_wr_en), 32'd0);
    repeat (2) @(negedge clk);
    check("t4_wr_cnt", wr_cnt - w0, 32'd1);
    check("t4_done_cnt", wr_done_cnt - d0, 32'd1);
    check("t4_err_cnt", err_cnt - e0, 32'd0);
    push_exp(16'h1234, 1'b1);
    issue(1'b0, 8'h05, 4'd0, '0);
    wait_done();

    // Reset during READ of beat 2
    push_exp(16'd2, 1'b0);
    issue(1'b0, 8'h00, 4'd3, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_read", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mem_addr", 32'(mem_addr), 32'd0);
    check("t5_outs", 32'({rsp_last, mem_rd_en, mem_wr_en, wr_done, err}), 32'd0);
    check("t5_drained", exp_q.size(), 32'd0);
    r1 = rd_cnt; cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("t5_no_beats", cnt, 32'd0);
    check("t5_no_reads", rd_cnt - r1, 32'd0);

    // Reset during WRITE
    w0 = wr_cnt; d0 = wr_done_cnt;
    issue(1'b1, 8'h06, 4'd0, 16'hBEEF);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5w_mem6", 32'(mem[6]), 32'd0);
    check("t5w_wr_cnt", wr_cnt - w0, 32'd0);
    check("t5w_done_cnt", wr_done_cnt - d0, 32'd0);
    push_exp(16'h0000, 1'b1);
    issue(1'b0, 8'h06, 4'd0, '0);
    wait_done();

    // Store to F0: dropped when protection is built in, performed otherwise
    w0 = wr_cnt; d0 = wr_done_cnt; e0 = err_cnt;
    issue(1'b1, 8'hF0, 4'd0, 16'd7);
    @(negedge clk);
`ifdef MEM_ACC_WPROT_EN
    check("t6_wr_en", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    check("t6_err", 32'(err), 32'd1);
    check("t6_wr_done", 32'(wr_done), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_wr_cnt", wr_cnt - w0, 32'd0);
    push_exp(16'h5555, 1'b1);
`else
    check("t6_wr_en", 32'(mem_wr_en), 32'd1);
    @(negedge clk);
    check("t6_err", 32'(err), 32'd0);
    check("t6_wr_done", 32'(wr_done), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_wr_cnt", wr_cnt - w0, 32'd1);
    push_exp(16'd7, 1'b1);
`endif
    check("t6_err_cnt_sum", (err_cnt - e0) + (wr_done_cnt - d0) * 2,
`ifdef MEM_ACC_WPROT_EN
          32'd3);
`else
          32'd2);
`endif
    issue(1'b0, 8'hF0, 4'd0, '0);
    wait_done();

    // req_valid held through a burst must not be accepted until IDLE
    push_exp(16'd2, 1'b0); push_exp(16'd3, 1'b0); push_exp(16'd10, 1'b0); push_exp(16'd15, 1'b1);
    push_exp(16'h00AA, 1'b1);
    p0 = pop_cnt;
    issue(1'b0, 8'h00, 4'd3, '0);
    issue(1'b0, 8'hFF, 4'd0, '0);
    check("t6_no_early_accept", pop_cnt - p0, 32'd4);
    wait_done();
    check("final_drained", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
